// File: rtl/fp_rnd_pack.sv
// -----------------------------------------------------------------------------
// fp_pkg + fp_rnd_pack
//
// Purpose
//   Rounding / packing back end shared by the FPU arithmetic units. It takes an
//   unrounded result with guard (g) and sticky (s) bits and applies the
//   selected IEEE-754 rounding mode. It detects overflow and underflow, packs
//   the final encoding and produces the RISC-V fflags. Two valid/ready
//   pipeline stages sit between the arithmetic units and FPU writeback.
//
// Ports
//   clk_i        in   clock, rising-edge active
//   rst_ni       in   asynchronous active-low reset
//   flush_i      in   synchronous kill of every in-flight entry
//   in_valid_i   in   urnd_i / rnd_mode_i valid
//   in_ready_o   out  block can accept this cycle
//   urnd_i       in   uround_res_t: u_result, rs={g,s}, round_en, invalid, exp_cout
//   rnd_mode_i   in   000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM, others RNE
//   out_valid_o  out  result_o / fflags_o valid
//   out_ready_i  in   downstream accepts
//   result_o     out  rounded, packed result (FP_WIDTH bits)
//   fflags_o     out  {NV,DZ,OF,UF,NX}; DZ is always 0
// -----------------------------------------------------------------------------
package fp_pkg;

    typedef enum logic [1:0] {FP32, FP64, FP16, BF16} fp_format_e;

    // Widest encoding carried on the unrounded-result bus.
    localparam int unsigned UR_W = 64;

    function automatic int unsigned exp_bits(input fp_format_e fmt);
        case (fmt)
            FP64:    return 11;
            FP16:    return 5;
            BF16:    return 8;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned man_bits(input fp_format_e fmt);
        case (fmt)
            FP64:    return 52;
            FP16:    return 10;
            BF16:    return 7;
            default: return 23;
        endcase
    endfunction

    function automatic int unsigned fp_width(input fp_format_e fmt);
        return 1 + exp_bits(fmt) + man_bits(fmt);
    endfunction

    // u_result holds {sign, exp, mant} right-aligned; bits above the format
    // width are ignored by the consumer.
    typedef struct packed {
        logic [UR_W-1:0] u_result;
        logic [1:0]      rs;        // {guard, sticky}
        logic            round_en;
        logic            invalid;
        logic [1:0]      exp_cout;  // 01: exponent already overflowed, 1x: underflowed
    } uround_res_t;

endpackage

module fp_rnd_pack
    import fp_pkg::*;
#(
    parameter fp_format_e FP_FORMAT = FP32
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               flush_i,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  uround_res_t                        urnd_i,
    input  logic [2:0]                         rnd_mode_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [fp_width(FP_FORMAT)-1:0]     result_o,
    output logic [4:0]                         fflags_o
);

    localparam int unsigned EW = exp_bits(FP_FORMAT);
    localparam int unsigned MW = man_bits(FP_FORMAT);
    localparam int unsigned FW = 1 + EW + MW;

    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam logic [4:0] FL_OF = 5'b00101;   // OF + NX
    localparam logic [4:0] FL_UF = 5'b00011;   // UF + NX

    // Increment decision; unlisted encodings fall through to RNE.
    function automatic logic f_round_inc(input logic [2:0] mode, input logic sign,
                                         input logic lsb, input logic g, input logic s);
        case (mode)
            RM_RTZ:  return 1'b0;
            RM_RDN:  return sign & (g | s);
            RM_RUP:  return ~sign & (g | s);
            RM_RMM:  return g;
            default: return g & (s | lsb);
        endcase
    endfunction

    // Saturation value on overflow: infinity when the mode rounds toward the
    // result's own infinity, largest finite magnitude otherwise.
    function automatic logic [FW-1:0] f_ovf_value(input logic [2:0] mode, input logic sign);
        logic to_inf;
        case (mode)
            RM_RTZ:  to_inf = 1'b0;
            RM_RDN:  to_inf = sign;
            RM_RUP:  to_inf = ~sign;
            default: to_inf = 1'b1;
        endcase
        if (to_inf)
            return {sign, {EW{1'b1}}, {MW{1'b0}}};
        return {sign, {(EW-1){1'b1}}, 1'b0, {MW{1'b1}}};
    endfunction

    // ------------------------------------------------------------------
    // Handshake / advance control
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_s2_load;
    logic w_s1_load;

    assign w_s2_load   = ~r_s2_valid | out_ready_i;
    assign w_s1_load   = ~r_s1_valid | w_s2_load;
    // A flush empties both stages, so the offered word is taken (and dropped).
    assign in_ready_o  = flush_i | w_s1_load;
    assign out_valid_o = r_s2_valid;

    // ------------------------------------------------------------------
    // Stage 1: register operands and decide the increment
    // ------------------------------------------------------------------
    logic [FW-1:0] r_s1_res;
    logic [1:0]    r_s1_rs;
    logic          r_s1_ren;
    logic          r_s1_inv;
    logic [1:0]    r_s1_cout;
    logic [2:0]    r_s1_mode;
    logic          r_s1_inc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_s1_valid <= 1'b0;
        else if (flush_i)
            r_s1_valid <= 1'b0;
        else if (w_s1_load)
            r_s1_valid <= in_valid_i;
    end

    always_ff @(posedge clk_i) begin
        if (w_s1_load && in_valid_i && !flush_i) begin
            r_s1_res  <= urnd_i.u_result[FW-1:0];
            r_s1_rs   <= urnd_i.rs;
            r_s1_ren  <= urnd_i.round_en;
            r_s1_inv  <= urnd_i.invalid;
            r_s1_cout <= urnd_i.exp_cout;
            r_s1_mode <= rnd_mode_i;
            r_s1_inc  <= urnd_i.round_en &
                         f_round_inc(rnd_mode_i, urnd_i.u_result[FW-1], urnd_i.u_result[0],
                                     urnd_i.rs[1], urnd_i.rs[0]);
        end
    end

    generate
        if (FW < UR_W) begin : g_unused_hi
            logic w_unused_hi;
            assign w_unused_hi = ^urnd_i.u_result[UR_W-1:FW];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 2: apply increment, classify, pack
    // ------------------------------------------------------------------
    logic          w_sign;
    logic [FW-2:0] w_mag;
    logic [FW-2:0] w_sum;
    logic [FW-2:0] w_probe;
    logic          w_uf;
    logic          w_of;
    logic [FW-1:0] w_res;
    logic [4:0]    w_flags;

    assign w_sign = r_s1_res[FW-1];
    assign w_mag  = r_s1_res[FW-2:0];
    // Exp and mant form one field, so a mantissa carry ripples into the exponent.
    assign w_sum  = w_mag + {{(FW-2){1'b0}}, r_s1_inc};
    // A guard bit at the top of the range counts as overflow in every mode,
    // so RTZ/RDN/RUP still flag OF when they saturate to max finite.
    assign w_probe = w_mag + {{(FW-2){1'b0}}, r_s1_inc | r_s1_rs[1]};
    assign w_uf    = r_s1_cout[1] | (r_s1_res[FW-2 -: EW] == '0);
    assign w_of    = (r_s1_cout == 2'b01) | (&w_probe[FW-2 -: EW]);

    always_comb begin
        w_res   = {w_sign, w_sum};
        w_flags = {4'b0000, |r_s1_rs};
        if (!r_s1_ren) begin
            w_res   = r_s1_res;
            w_flags = {r_s1_inv, 4'b0000};
        end else if (w_uf) begin
            w_res   = {w_sign, {(FW-1){1'b0}}};
            w_flags = FL_UF;
        end else if (w_of) begin
            w_res   = f_ovf_value(r_s1_mode, w_sign);
            w_flags = FL_OF;
        end
    end

    logic [FW-1:0] r_result;
    logic [4:0]    r_fflags;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_fflags   <= '0;
        end else begin
            if (flush_i)
                r_s2_valid <= 1'b0;
            else if (w_s2_load)
                r_s2_valid <= r_s1_valid;
            // Output payload only moves when a real entry advances, which keeps
            // it stable under backpressure.
            if (w_s2_load && r_s1_valid && !flush_i) begin
                r_result <= w_res;
                r_fflags <= w_flags;
            end
        end
    end

    assign result_o = r_result;
    assign fflags_o = r_fflags;

endmodule
